// File: rtl/io_bank_pkg.sv
// io_bank_pkg: shared types and constants for the IO bank sequencer.
//   bank_state_e   sequencer states
//   CFG_OE/PULL/IE bit positions inside a per-pad config word {oe_allow, pull_en, ie_en}
//   CFG_RST        per-pad config after reset: outputs blocked, pull on, input buffer on
package io_bank_pkg;

  typedef enum logic [2:0] {
    OFF      = 3'd0,
    WAIT_POC = 3'd1,
    IE_ON    = 3'd2,
    RAMP     = 3'd3,
    RUN      = 3'd4
  } bank_state_e;

  localparam int CFG_OE   = 2;
  localparam int CFG_PULL = 1;
  localparam int CFG_IE   = 0;

  localparam logic [2:0] CFG_RST = 3'b011;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/io_sync2.sv
// io_sync2: W-wide two-flop synchroniser with asynchronous active-high reset.
//   clk  in   sampling clock
//   rst  in   async reset, active-high (both stages clear to 0)
//   d    in   W  asynchronous input
//   q    out  W  synchronised output, 2-cycle latency
module io_sync2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/io_bank_seq.sv
// io_bank_seq: power-up sequencer and config controller for a bank of NPAD pads.
// Holds pads safe while poc=1, waits SETTLE clean cycles, enables input buffers,
// then releases output enables GRP pads every STEP cycles to limit SSO.
//   clk        in   bank clock
//   rst        in   async reset, active-high
//   poc        in   1 = IO supply not valid
//   cfg_vld    in   config write request
//   cfg_rdy    out  config write accept (write on cfg_vld & cfg_rdy)
//   cfg_addr   in   5     pad index; indices >= NPAD are accepted and dropped
//   cfg_wdata  in   3     {oe_allow, pull_en, ie_en}
//   do_core    in   NPAD  core output data
//   oe_core    in   NPAD  core output enable, active-high
//   pad_do     out  NPAD  pad DO (named pad_do because "do" is a reserved word)
//   oen        out  NPAD  pad OEN, active-low
//   ren        out  NPAD  pad REN, active-low pull enable
//   ie         out  NPAD  pad IE
//   di         in   NPAD  pad DI, asynchronous
//   di_sync    out  NPAD  di through a 2-flop synchroniser
//   bank_up    out  1 while in RUN
// Optional macro IO_BANK_BSCAN_OVR_EN adds bsen, bs_do, bs_oen: while bsen=1 and
// poc=0 the pad outputs follow the boundary-scan inputs instead of the sequencer.
//
// state    | meaning
// OFF      | supply invalid or just reset; pads held safe
// WAIT_POC | counting SETTLE consecutive poc=0 cycles
// IE_ON    | one cycle: input buffers enabled, first OE group released
// RAMP     | one more OE group released every STEP cycles
// RUN      | all groups released; bank usable
module io_bank_seq
  import io_bank_pkg::*;
#(
  parameter int NPAD   = 8,
  parameter int GRP    = 2,
  parameter int STEP   = 4,
  parameter int SETTLE = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            poc,
  input  logic            cfg_vld,
  output logic            cfg_rdy,
  input  logic [4:0]      cfg_addr,
  input  logic [2:0]      cfg_wdata,
  input  logic [NPAD-1:0] do_core,
  input  logic [NPAD-1:0] oe_core,
  output logic [NPAD-1:0] pad_do,
  output logic [NPAD-1:0] oen,
  output logic [NPAD-1:0] ren,
  output logic [NPAD-1:0] ie,
  input  logic [NPAD-1:0] di,
`ifdef IO_BANK_BSCAN_OVR_EN
  input  logic            bsen,
  input  logic [NPAD-1:0] bs_do,
  input  logic [NPAD-1:0] bs_oen,
`endif
  output logic [NPAD-1:0] di_sync,
  output logic            bank_up
);

  localparam int CW  = $clog2(max2(STEP, SETTLE) + 1);
  localparam int NRW = $clog2(NPAD + 1);

  bank_state_e     state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [NRW-1:0]  n_rel, n_rel_nxt, rel_add;
  logic [2:0]      cfg_tbl [NPAD];
  logic [NPAD-1:0] released, oe_allow, pull_en, ie_en;
  logic [NPAD-1:0] do_nxt, oen_nxt, ie_nxt;
  logic            all_rel, ie_phase, rdy_nxt;

  always_comb begin
    for (int i = 0; i < NPAD; i++) begin
      released[i] = (i < int'(n_rel));
      oe_allow[i] = cfg_tbl[i][CFG_OE];
      pull_en[i]  = cfg_tbl[i][CFG_PULL];
      ie_en[i]    = cfg_tbl[i][CFG_IE];
    end
  end

  // Released pads are tracked as a count; the last group saturates at NPAD.
  assign all_rel = (n_rel == NRW'(NPAD));
  assign rel_add = (int'(n_rel) + GRP >= NPAD) ? NRW'(NPAD) : n_rel + NRW'(GRP);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    n_rel_nxt = n_rel;
    if (poc) begin
      state_nxt = OFF;
      cnt_nxt   = '0;
      n_rel_nxt = '0;
    end else begin
      case (state)
        OFF: begin
          state_nxt = WAIT_POC;
          cnt_nxt   = CW'(SETTLE - 1);
        end
        WAIT_POC: begin
          if (cnt == '0) state_nxt = IE_ON;
          else           cnt_nxt   = cnt - CW'(1);
        end
        IE_ON: begin
          state_nxt = RAMP;
          n_rel_nxt = rel_add;
          cnt_nxt   = CW'(STEP - 1);
        end
        RAMP: begin
          if (all_rel) begin
            state_nxt = RUN;
          end else if (cnt == '0) begin
            n_rel_nxt = rel_add;
            cnt_nxt   = CW'(STEP - 1);
          end else begin
            cnt_nxt = cnt - CW'(1);
          end
        end
        RUN: ;
        default: state_nxt = OFF;
      endcase
    end
  end

  always_comb begin
    ie_phase = (state == IE_ON) || (state == RAMP) || (state == RUN);
    rdy_nxt  = (state_nxt == OFF) || (state_nxt == WAIT_POC) || (state_nxt == RUN);
    do_nxt   = do_core;
    oen_nxt  = poc ? '1 : ~(released & oe_allow & oe_core);
    ie_nxt   = (ie_phase && !poc) ? ie_en : '0;
`ifdef IO_BANK_BSCAN_OVR_EN
    if (bsen && !poc) begin
      do_nxt  = bs_do;
      oen_nxt = bs_oen;
      ie_nxt  = '1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= OFF;
      cnt   <= '0;
      n_rel <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      n_rel <= n_rel_nxt;
    end
  end

  // cfg_rdy is registered from the next state so it lines up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_rdy <= 1'b0;
      pad_do  <= '0;
      oen     <= '1;
      ren     <= '0;
      ie      <= '0;
      for (int i = 0; i < NPAD; i++) cfg_tbl[i] <= CFG_RST;
    end else begin
      cfg_rdy <= rdy_nxt;
      pad_do  <= do_nxt;
      oen     <= oen_nxt;
      ren     <= ~pull_en;
      ie      <= ie_nxt;
      for (int i = 0; i < NPAD; i++)
        if (cfg_vld && cfg_rdy && cfg_addr == 5'(i)) cfg_tbl[i] <= cfg_wdata;
    end
  end

  assign bank_up = (state == RUN);

  io_sync2 #(.W(NPAD)) u_di_sync (
    .clk (clk),
    .rst (rst),
    .d   (di),
    .q   (di_sync)
  );

endmodule
